// File: rtl/mips_inst_encoder.sv
// Streaming MIPS encoder: mnemonic + operand fields in, one registered 32-bit
// machine word out with a sequential instruction-memory word address.
module mips_inst_encoder #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          restart,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    mnem,
  input  logic [4:0]    rs,
  input  logic [4:0]    rt,
  input  logic [4:0]    rd,
  input  logic [4:0]    sa,
  input  logic [15:0]   imm,
  input  logic [25:0]   target,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic [AW-1:0] out_addr,
  output logic          err,
  output logic [AW:0]   count
);

  localparam logic [4:0] M_ADD  = 5'd0;
  localparam logic [4:0] M_SUB  = 5'd1;
  localparam logic [4:0] M_AND  = 5'd2;
  localparam logic [4:0] M_OR   = 5'd3;
  localparam logic [4:0] M_XOR  = 5'd4;
  localparam logic [4:0] M_SLL  = 5'd5;
  localparam logic [4:0] M_SRL  = 5'd6;
  localparam logic [4:0] M_SRA  = 5'd7;
  localparam logic [4:0] M_JR   = 5'd8;
  localparam logic [4:0] M_ADDI = 5'd9;
  localparam logic [4:0] M_ANDI = 5'd10;
  localparam logic [4:0] M_ORI  = 5'd11;
  localparam logic [4:0] M_XORI = 5'd12;
  localparam logic [4:0] M_LW   = 5'd13;
  localparam logic [4:0] M_SW   = 5'd14;
  localparam logic [4:0] M_BEQ  = 5'd15;
  localparam logic [4:0] M_BNE  = 5'd16;
  localparam logic [4:0] M_LUI  = 5'd17;
  localparam logic [4:0] M_J    = 5'd18;
  localparam logic [4:0] M_JAL  = 5'd19;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_SRA = 6'b000011;
  localparam logic [5:0] F_JR  = 6'b001000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  logic [31:0]   word_enc;
  logic          legal;

  logic          valid_q, valid_d;
  logic [31:0]   data_q, data_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   count_q, count_d;
  logic          err_q, err_d;

  logic          accept, emit;

  // Field forcing happens here so the output stage only ever stores clean words.
  always_comb begin
    word_enc = '0;
    legal    = 1'b1;
    case (mnem)
      M_ADD:  word_enc = {OP_RTYPE, rs, rt, rd, 5'd0, F_ADD};
      M_SUB:  word_enc = {OP_RTYPE, rs, rt, rd, 5'd0, F_SUB};
      M_AND:  word_enc = {OP_RTYPE, rs, rt, rd, 5'd0, F_AND};
      M_OR:   word_enc = {OP_RTYPE, rs, rt, rd, 5'd0, F_OR};
      M_XOR:  word_enc = {OP_RTYPE, rs, rt, rd, 5'd0, F_XOR};
      M_SLL:  word_enc = {OP_RTYPE, 5'd0, rt, rd, sa, F_SLL};
      M_SRL:  word_enc = {OP_RTYPE, 5'd0, rt, rd, sa, F_SRL};
      M_SRA:  word_enc = {OP_RTYPE, 5'd0, rt, rd, sa, F_SRA};
      M_JR:   word_enc = {OP_RTYPE, rs, 5'd0, 5'd0, 5'd0, F_JR};
      M_ADDI: word_enc = {OP_ADDI, rs, rt, imm};
      M_ANDI: word_enc = {OP_ANDI, rs, rt, imm};
      M_ORI:  word_enc = {OP_ORI, rs, rt, imm};
      M_XORI: word_enc = {OP_XORI, rs, rt, imm};
      M_LW:   word_enc = {OP_LW, rs, rt, imm};
      M_SW:   word_enc = {OP_SW, rs, rt, imm};
      M_BEQ:  word_enc = {OP_BEQ, rs, rt, imm};
      M_BNE:  word_enc = {OP_BNE, rs, rt, imm};
      M_LUI:  word_enc = {OP_LUI, 5'd0, rt, imm};
      M_J:    word_enc = {OP_J, target};
      M_JAL:  word_enc = {OP_JAL, target};
      default: legal = 1'b0;
    endcase
  end

  assign in_ready = ~reset & ~restart & (~valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign emit     = valid_q & out_ready & ~restart;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    addr_d  = addr_q;
    count_d = count_q;
    err_d   = err_q;
    if (restart) begin
      valid_d = 1'b0;
      data_d  = '0;
      addr_d  = '0;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      if (emit) begin
        valid_d = 1'b0;
        addr_d  = addr_q + AW'(1);
        if (count_q != '1) begin
          count_d = count_q + (AW+1)'(1);
        end
      end
      // A same-cycle legal accept overrides the emit's clear of valid.
      if (accept && legal) begin
        valid_d = 1'b1;
        data_d  = word_enc;
      end
      if (accept && !legal) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_addr  = addr_q;
  assign count     = count_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mips_inst_encoder.sv
// Directed bench for mips_inst_encoder: an AW=8 and an AW=2 instance share all
// inputs so address wrap and count saturation are observed on the narrow one.
module tb_mips_inst_encoder;

  logic        clk = 1'b0;
  logic        reset, restart, in_valid, out_ready;
  logic [4:0]  mnem, rs, rt, rd, sa;
  logic [15:0] imm;
  logic [25:0] target;

  logic        in_ready8, out_valid8, err8;
  logic [31:0] out_data8;
  logic [7:0]  out_addr8;
  logic [8:0]  count8;

  logic        in_ready2, out_valid2, err2;
  logic [31:0] out_data2;
  logic [1:0]  out_addr2;
  logic [2:0]  count2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mips_inst_encoder #(.AW(8)) u8 (
    .clk(clk), .reset(reset), .restart(restart),
    .in_valid(in_valid), .in_ready(in_ready8),
    .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .sa(sa), .imm(imm), .target(target),
    .out_valid(out_valid8), .out_ready(out_ready),
    .out_data(out_data8), .out_addr(out_addr8), .err(err8), .count(count8)
  );

  mips_inst_encoder #(.AW(2)) u2 (
    .clk(clk), .reset(reset), .restart(restart),
    .in_valid(in_valid), .in_ready(in_ready2),
    .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .sa(sa), .imm(imm), .target(target),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_addr(out_addr2), .err(err2), .count(count2)
  );

  typedef struct {
    logic [4:0]  m, s, t, d, a;
    logic [15:0] i;
    logic [25:0] g;
    logic [31:0] w;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inst(input logic [4:0] m, input logic [4:0] s, input logic [4:0] t,
                          input logic [4:0] d, input logic [4:0] a,
                          input logic [15:0] i, input logic [25:0] g);
    mnem = m; rs = s; rt = t; rd = d; sa = a; imm = i; target = g;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    #1;
    chk("restart_in_ready", 32'(in_ready8), 32'd0);
    tick();
    restart = 1'b0;
    #1;
  endtask

  initial begin
    vecs[0]  = '{5'd7,  5'd3,  5'd9,  5'd10, 5'd31, 16'h0000, 26'h0,       32'h000957C3};
    vecs[1]  = '{5'd8,  5'd31, 5'd5,  5'd6,  5'd7,  16'h0000, 26'h0,       32'h03E00008};
    vecs[2]  = '{5'd17, 5'd5,  5'd7,  5'd0,  5'd0,  16'hBEEF, 26'h0,       32'h3C07BEEF};
    vecs[3]  = '{5'd16, 5'd1,  5'd2,  5'd0,  5'd0,  16'hFFFE, 26'h0,       32'h1422FFFE};
    vecs[4]  = '{5'd19, 5'd0,  5'd0,  5'd0,  5'd0,  16'h0000, 26'h3FFFFFF, 32'h0FFFFFFF};
    vecs[5]  = '{5'd14, 5'd29, 5'd31, 5'd0,  5'd0,  16'h0010, 26'h0,       32'hAFBF0010};
    vecs[6]  = '{5'd4,  5'd1,  5'd2,  5'd3,  5'd5,  16'h0000, 26'h0,       32'h00221826};
    vecs[7]  = '{5'd6,  5'd9,  5'd8,  5'd7,  5'd1,  16'h0000, 26'h0,       32'h00083842};
    vecs[8]  = '{5'd10, 5'd2,  5'd3,  5'd0,  5'd0,  16'h8000, 26'h0,       32'h30438000};
    vecs[9]  = '{5'd9,  5'd0,  5'd1,  5'd0,  5'd0,  16'h7FFF, 26'h0,       32'h20017FFF};
    vecs[10] = '{5'd15, 5'd4,  5'd4,  5'd0,  5'd0,  16'h0000, 26'h0,       32'h10840000};
    vecs[11] = '{5'd2,  5'd6,  5'd7,  5'd8,  5'd2,  16'h0000, 26'h0,       32'h00C74024};
    vecs[12] = '{5'd3,  5'd1,  5'd1,  5'd1,  5'd0,  16'h0000, 26'h0,       32'h00210825};

    reset = 1'b1; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_inst(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    #1;
    chk("rst_in_ready", 32'(in_ready8), 32'd0);
    chk("rst_out_valid", 32'(out_valid8), 32'd0);
    chk("rst_out_data", out_data8, 32'd0);
    chk("rst_out_addr", 32'(out_addr8), 32'd0);
    chk("rst_count", 32'(count8), 32'd0);
    chk("rst_err", 32'(err8), 32'd0);
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("idle_in_ready", 32'(in_ready8), 32'd1);

    // add: sa must be forced to zero
    set_inst(5'd0, 5'd1, 5'd2, 5'd3, 5'd9, 16'h0, 26'h0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    $display("txn add: data=%08h addr=%0d", out_data8, out_addr8);
    chk("add_valid", 32'(out_valid8), 32'd1);
    chk("add_data", out_data8, 32'h00221820);
    chk("add_addr", 32'(out_addr8), 32'd0);
    chk("add_stall_in_ready", 32'(in_ready8), 32'd0);
    out_ready = 1'b1;
    tick();
    chk("add_emit_count", 32'(count8), 32'd1);
    chk("add_emit_addr", 32'(out_addr8), 32'd1);
    chk("add_emit_valid", 32'(out_valid8), 32'd0);
    do_restart();
    chk("rs_count", 32'(count8), 32'd0);
    chk("rs_addr", 32'(out_addr8), 32'd0);

    // lw then j back to back
    set_inst(5'd13, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0);
    in_valid = 1'b1;
    tick();
    $display("txn lw: data=%08h addr=%0d", out_data8, out_addr8);
    chk("lw_data", out_data8, 32'h8FA80004);
    chk("lw_addr", 32'(out_addr8), 32'd0);
    set_inst(5'd18, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100000);
    tick();
    in_valid = 1'b0;
    $display("txn j: data=%08h addr=%0d", out_data8, out_addr8);
    chk("j_valid", 32'(out_valid8), 32'd1);
    chk("j_data", out_data8, 32'h08100000);
    chk("j_addr", 32'(out_addr8), 32'd1);
    tick();
    chk("lwj_count", 32'(count8), 32'd2);
    chk("lwj_valid", 32'(out_valid8), 32'd0);

    // sll held under backpressure, then a sub accepted in the emit cycle
    do_restart();
    out_ready = 1'b0;
    set_inst(5'd5, 5'd7, 5'd1, 5'd2, 5'd4, 16'h0, 26'h0);
    in_valid = 1'b1;
    tick();
    set_inst(5'd1, 5'd4, 5'd5, 5'd6, 5'd3, 16'h0, 26'h0);
    for (int k = 0; k < 3; k++) begin
      $display("txn sll hold %0d: data=%08h addr=%0d", k, out_data8, out_addr8);
      chk("sll_hold_data", out_data8, 32'h00011100);
      chk("sll_hold_ready", 32'(in_ready8), 32'd0);
      chk("sll_hold_addr", 32'(out_addr8), 32'd0);
      tick();
    end
    chk("sll_hold_count", 32'(count8), 32'd0);
    out_ready = 1'b1;
    #1;
    chk("sll_release_ready", 32'(in_ready8), 32'd1);
    tick();
    in_valid = 1'b0;
    $display("txn sub: data=%08h addr=%0d", out_data8, out_addr8);
    chk("sub_data", out_data8, 32'h00853022);
    chk("sub_addr", 32'(out_addr8), 32'd1);
    chk("sub_valid", 32'(out_valid8), 32'd1);
    chk("sub_count", 32'(count8), 32'd1);
    tick();
    chk("sub_emit_count", 32'(count8), 32'd2);

    // illegal mnemonic dropped, sticky err
    do_restart();
    set_inst(5'd25, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1234, 26'h0);
    in_valid = 1'b1;
    tick();
    $display("txn illegal: valid=%0d err=%0d", out_valid8, err8);
    chk("ill_valid", 32'(out_valid8), 32'd0);
    chk("ill_err", 32'(err8), 32'd1);
    chk("ill_addr", 32'(out_addr8), 32'd0);
    set_inst(5'd11, 5'd3, 5'd4, 5'd0, 5'd0, 16'h00FF, 26'h0);
    tick();
    in_valid = 1'b0;
    $display("txn ori: data=%08h addr=%0d", out_data8, out_addr8);
    chk("ori_data", out_data8, 32'h346400FF);
    chk("ori_addr", 32'(out_addr8), 32'd0);
    tick();
    chk("ori_count", 32'(count8), 32'd1);
    chk("ori_err_sticky", 32'(err8), 32'd1);
    do_restart();
    chk("rs_err", 32'(err8), 32'd0);

    // stream of 13 words: encodings, AW=2 wrap and count saturation
    in_valid = 1'b1;
    for (int k = 0; k < 13; k++) begin
      set_inst(vecs[k].m, vecs[k].s, vecs[k].t, vecs[k].d, vecs[k].a, vecs[k].i, vecs[k].g);
      tick();
      $display("txn stream %0d: data=%08h addr8=%0d addr2=%0d count2=%0d",
               k, out_data8, out_addr8, out_addr2, count2);
      chk("stream_data", out_data8, vecs[k].w);
      chk("stream_addr8", 32'(out_addr8), 32'(k));
      chk("stream_addr2", 32'(out_addr2), 32'(k % 4));
      chk("stream_count2", 32'(count2), 32'((k < 7) ? k : 7));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_count8", 32'(count8), 32'd13);
    chk("stream_count2_sat", 32'(count2), 32'd7);
    chk("stream_addr2_end", 32'(out_addr2), 32'd1);

    // restart while a word is held
    out_ready = 1'b0;
    set_inst(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("pre_restart_valid", 32'(out_valid8), 32'd1);
    do_restart();
    chk("restart_valid", 32'(out_valid8), 32'd0);
    chk("restart_addr", 32'(out_addr8), 32'd0);
    chk("restart_count", 32'(count8), 32'd0);

    // asynchronous reset while a word is held
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("pre_reset_valid", 32'(out_valid8), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_valid", 32'(out_valid8), 32'd0);
    chk("async_reset_ready", 32'(in_ready8), 32'd0);
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    set_inst(5'd12, 5'd2, 5'd3, 5'd0, 5'd0, 16'hA5A5, 26'h0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    $display("txn xori: data=%08h addr=%0d", out_data8, out_addr8);
    chk("post_reset_data", out_data8, 32'h3843A5A5);
    chk("post_reset_addr", 32'(out_addr8), 32'd0);
    tick();
    chk("post_reset_count", 32'(count8), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
